// File: rtl/run_monitor.sv
// ---------------------------------------------------------------------------
// run_monitor
//   Run monitor for the pipeline CPU. It counts cycles spent running and
//   counts NUM_EV independent event channels. It detects halt and then waits
//   a drain delay, so that in-flight writes land before DONE is reported.
//   A watchdog forces TIMEOUT if the CPU never halts. Every counter
//   saturates at all-ones and never wraps.
//
// Ports
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   halt       in   1             CPU halt level, sampled in RUN only
//   ret_val    in   RET_W         return value, captured on the halt edge
//   ev         in   NUM_EV        per-channel event pulse
//   clr        in   1             synchronous clear back to RUN
//   state      out  2             0 RUN, 1 DRAIN, 2 DONE, 3 TIMEOUT
//   done       out  1             state == DONE
//   timed_out  out  1             state == TIMEOUT
//   ret_q      out  RET_W         captured return value
//   cycle_cnt  out  CNT_W         cycles spent in RUN, including the halt cycle
//   ev_cnt     out  NUM_EV*CNT_W  channel i in bits [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module run_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_EV     = 4,
  parameter int unsigned RET_W      = 16,
  parameter int unsigned TIMEOUT    = 500000,
  parameter int unsigned HALT_DRAIN = 2,
  parameter bit          FINISH_SIM = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    halt,
  input  logic [RET_W-1:0]        ret_val,
  input  logic [NUM_EV-1:0]       ev,
  input  logic                    clr,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    timed_out,
  output logic [RET_W-1:0]        ret_q,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [NUM_EV*CNT_W-1:0] ev_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // The drain counter only ever holds HALT_DRAIN-1 down to 0.
  localparam int unsigned     DW         = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = (HALT_DRAIN == 0) ? '0 : DW'(HALT_DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t        state_q, state_next;
  logic [DW-1:0] drain_q;
  logic          wd_hit;
  logic          counting;

  // The watchdog fires on the edge that takes cycle_cnt from TIMEOUT-1 to
  // TIMEOUT. A zero TIMEOUT disables the watchdog entirely.
  assign wd_hit   = (TIMEOUT != 0) && (64'(cycle_cnt) == 64'(TIMEOUT) - 64'd1);
  assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so that every register samples
  // the pre-edge values, whatever order the processes are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. The priority is clr > halt > watchdog.
  // -------------------------------------------------------------------------
  // NOTE: default assignment first so that no path leaves state_next
  // unassigned. An unassigned path would infer a latch.
  always_comb begin
    state_next = state_q;
    if (clr) begin
      state_next = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt)        state_next = (HALT_DRAIN == 0) ? ST_DONE : ST_DRAIN;
          else if (wd_hit) state_next = ST_TIMEOUT;
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_next = ST_DONE;
        end
        default: state_next = state_q;  // DONE and TIMEOUT are sticky
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. This comes from the state register only.
  // -------------------------------------------------------------------------
  always_comb begin
    state     = state_q;
    done      = (state_q == ST_DONE);
    timed_out = (state_q == ST_TIMEOUT);
  end

  // -------------------------------------------------------------------------
  // Counters, captured return value and drain counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      ev_cnt    <= '0;
      ret_q     <= '0;
      drain_q   <= '0;
    end else if (clr) begin
      // On a clear edge, ev and halt are discarded.
      cycle_cnt <= '0;
      ev_cnt    <= '0;
      ret_q     <= '0;
      drain_q   <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (halt) begin
          ret_q   <= ret_val;
          drain_q <= DRAIN_LOAD;
        end
      end

      if (state_q == ST_DRAIN && drain_q != '0) drain_q <= drain_q - DW'(1);

      if (counting) begin
        for (int i = 0; i < NUM_EV; i++) begin
          if (ev[i] && ev_cnt[i*CNT_W +: CNT_W] != CNT_MAX)
            ev_cnt[i*CNT_W +: CNT_W] <= ev_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation-only end-of-run report, issued on the edge that enters DONE
  // or TIMEOUT. DONE can only be entered straight from RUN when the drain
  // delay is zero. In that case the value being captured on this edge is
  // ret_val.
  always @(posedge clk) begin
    if (rst_n && state_q != ST_DONE && state_next == ST_DONE) begin
      $display("Finished with << %0d >>", (state_q == ST_RUN) ? ret_val : ret_q);
      if (FINISH_SIM) $finish;
    end
    if (rst_n && state_q != ST_TIMEOUT && state_next == ST_TIMEOUT) begin
      $display("ran for %0d cycles", TIMEOUT);
      if (FINISH_SIM) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_run_monitor
//   Drives three run_monitor instances from shared stimulus:
//     u_a : CNT_W=8, TIMEOUT=20, HALT_DRAIN=2
//     u_b : CNT_W=8, TIMEOUT=20, HALT_DRAIN=0
//     u_c : CNT_W=4, TIMEOUT=0 (watchdog off), HALT_DRAIN=1
//   A behavioural model of each instance is checked every cycle. Directed
//   scenarios add hand-computed literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_run_monitor;

  localparam int NI = 3;
  localparam int NE = 4;
  localparam int CFG_CW [NI] = '{8, 8, 4};
  localparam int CFG_TO [NI] = '{20, 20, 0};
  localparam int CFG_HD [NI] = '{2, 0, 1};

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic [15:0] ret_val;
  logic [3:0]  ev;
  logic        clr;

  logic [1:0]  st_a, st_b, st_c;
  logic        dn_a, dn_b, dn_c;
  logic        to_a, to_b, to_c;
  logic [15:0] rq_a, rq_b, rq_c;
  logic [7:0]  cy_a, cy_b;
  logic [3:0]  cy_c;
  logic [31:0] ec_a, ec_b;
  logic [15:0] ec_c;

  run_monitor #(.CNT_W(8), .NUM_EV(4), .RET_W(16), .TIMEOUT(20), .HALT_DRAIN(2), .FINISH_SIM(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .halt(halt), .ret_val(ret_val), .ev(ev), .clr(clr),
    .state(st_a), .done(dn_a), .timed_out(to_a), .ret_q(rq_a), .cycle_cnt(cy_a), .ev_cnt(ec_a));
  run_monitor #(.CNT_W(8), .NUM_EV(4), .RET_W(16), .TIMEOUT(20), .HALT_DRAIN(0), .FINISH_SIM(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .halt(halt), .ret_val(ret_val), .ev(ev), .clr(clr),
    .state(st_b), .done(dn_b), .timed_out(to_b), .ret_q(rq_b), .cycle_cnt(cy_b), .ev_cnt(ec_b));
  run_monitor #(.CNT_W(4), .NUM_EV(4), .RET_W(16), .TIMEOUT(0), .HALT_DRAIN(1), .FINISH_SIM(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .halt(halt), .ret_val(ret_val), .ev(ev), .clr(clr),
    .state(st_c), .done(dn_c), .timed_out(to_c), .ret_q(rq_c), .cycle_cnt(cy_c), .ev_cnt(ec_c));

  // Observed outputs gathered into arrays indexed by instance.
  logic [63:0] a_st [NI];
  logic [63:0] a_dn [NI];
  logic [63:0] a_to [NI];
  logic [63:0] a_rq [NI];
  logic [63:0] a_cy [NI];
  logic [63:0] a_ev [NI][NE];

  assign a_st[0] = 64'(st_a);  assign a_st[1] = 64'(st_b);  assign a_st[2] = 64'(st_c);
  assign a_dn[0] = 64'(dn_a);  assign a_dn[1] = 64'(dn_b);  assign a_dn[2] = 64'(dn_c);
  assign a_to[0] = 64'(to_a);  assign a_to[1] = 64'(to_b);  assign a_to[2] = 64'(to_c);
  assign a_rq[0] = 64'(rq_a);  assign a_rq[1] = 64'(rq_b);  assign a_rq[2] = 64'(rq_c);
  assign a_cy[0] = 64'(cy_a);  assign a_cy[1] = 64'(cy_b);  assign a_cy[2] = 64'(cy_c);

  for (genvar i = 0; i < NE; i++) begin : g_ev
    assign a_ev[0][i] = 64'(ec_a[i*8 +: 8]);
    assign a_ev[1][i] = 64'(ec_b[i*8 +: 8]);
    assign a_ev[2][i] = 64'(ec_c[i*4 +: 4]);
  end

  // -------------------------------------------------------------------------
  // Check bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model.
  // Phase: 0 running, 1 draining, 2 finished, 3 watchdog.
  // m_left is the number of edges still to go before the finish is reported.
  // -------------------------------------------------------------------------
  int              m_st   [NI];
  longint unsigned m_cyc  [NI];
  longint unsigned m_ret  [NI];
  int              m_left [NI];
  longint unsigned m_ev   [NI][NE];

  function automatic longint unsigned sat_inc(input longint unsigned v, input int w);
    longint unsigned max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

  task automatic model_clear(input int k);
    m_st[k] = 0; m_cyc[k] = 0; m_ret[k] = 0; m_left[k] = 0;
    for (int i = 0; i < NE; i++) m_ev[k][i] = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (!rst_n || clr) begin
        model_clear(k);
      end else if (m_st[k] == 0 || m_st[k] == 1) begin
        for (int i = 0; i < NE; i++)
          if (ev[i]) m_ev[k][i] = sat_inc(m_ev[k][i], CFG_CW[k]);
        if (m_st[k] == 0) begin
          m_cyc[k] = sat_inc(m_cyc[k], CFG_CW[k]);
          if (halt) begin
            m_ret[k]  = 64'(ret_val);
            m_left[k] = CFG_HD[k];
            m_st[k]   = (CFG_HD[k] == 0) ? 2 : 1;
          end else if (CFG_TO[k] != 0 && m_cyc[k] == 64'(CFG_TO[k])) begin
            m_st[k] = 3;
          end
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) m_st[k] = 2;
        end
      end
    end
  endtask

  // Compare process: the model advances on each edge, and the DUT is sampled
  // 1 ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("u%0d.state", k),     a_st[k], 64'(m_st[k]));
      check($sformatf("u%0d.done", k),      a_dn[k], 64'(m_st[k] == 2));
      check($sformatf("u%0d.timed_out", k), a_to[k], 64'(m_st[k] == 3));
      check($sformatf("u%0d.ret_q", k),     a_rq[k], m_ret[k]);
      check($sformatf("u%0d.cycle_cnt", k), a_cy[k], m_cyc[k]);
      for (int i = 0; i < NE; i++)
        check($sformatf("u%0d.ev_cnt[%0d]", k, i), a_ev[k][i], m_ev[k][i]);
    end
  end

  // -------------------------------------------------------------------------
  // Clock and directed stimulus. Inputs change just after the falling edge.
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; ret_val = '0; ev = '0; clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("reset a.state", 64'(st_a), 0);
    check("reset a.cycle_cnt", 64'(cy_a), 0);

    // Halt on the 10th RUN edge with drain delay 2. ev[2] pulses while
    // draining and after DONE.
    tick(9);
    halt = 1'b1; ret_val = 16'd42;
    tick(1);
    halt = 1'b0; ev = 4'b0100;
    check("halt a.state drain", 64'(st_a), 1);
    check("halt a.cycle_cnt", 64'(cy_a), 10);
    check("halt b.done (drain 0)", 64'(dn_b), 1);
    tick(1);
    check("drain a.done early", 64'(dn_a), 0);
    tick(1);
    check("drain a.done", 64'(dn_a), 1);
    check("drain a.ret_q", 64'(rq_a), 42);
    check("drain a.cycle_cnt frozen", 64'(cy_a), 10);
    tick(3);
    ev = 4'b0000;
    check("ev after halt a.ev2", 64'(ec_a[16 +: 8]), 2);
    check("ev after halt c.ev2", 64'(ec_c[8 +: 4]), 1);

    // Clear in DONE. ev and halt on the clear edge are discarded.
    clr = 1'b1; halt = 1'b1; ev = 4'b1111;
    tick(1);
    clr = 1'b0; halt = 1'b0; ev = 4'b0000;
    check("clr a.state", 64'(st_a), 0);
    check("clr a.cycle_cnt", 64'(cy_a), 0);
    check("clr a.ret_q", 64'(rq_a), 0);
    check("clr a.ev2", 64'(ec_a[16 +: 8]), 0);

    // Watchdog at 20 cycles. u_c has no watchdog and saturates at 15.
    tick(19);
    check("wd a.timed_out early", 64'(to_a), 0);
    tick(1);
    check("wd a.timed_out", 64'(to_a), 1);
    check("wd a.cycle_cnt", 64'(cy_a), 20);
    tick(5);
    check("wd a.timed_out sticky", 64'(to_a), 1);
    check("wd a.cycle_cnt frozen", 64'(cy_a), 20);
    check("wd c.state run", 64'(st_c), 0);
    check("wd c.cycle_cnt sat", 64'(cy_c), 15);

    // Events: ev[0] high for 20 cycles, ev[1] toggling for 8 cycles.
    do_clr();
    for (int j = 0; j < 20; j++) begin
      ev[0] = 1'b1;
      ev[1] = (j < 8) && (j % 2 == 0);
      tick(1);
    end
    ev = 4'b0000;
    check("events c.ev0 sat", 64'(ec_c[0 +: 4]), 15);
    check("events c.ev1", 64'(ec_c[4 +: 4]), 4);
    check("events a.ev0", 64'(ec_a[0 +: 8]), 20);

    // Halt on the same edge as the watchdog: halt wins.
    do_clr();
    tick(19);
    halt = 1'b1; ret_val = 16'd7;
    tick(1);
    halt = 1'b0;
    check("tie b.done", 64'(dn_b), 1);
    check("tie b.timed_out", 64'(to_b), 0);
    check("tie b.cycle_cnt", 64'(cy_b), 20);
    check("tie b.ret_q", 64'(rq_b), 7);
    check("tie a.state drain", 64'(st_a), 1);
    tick(2);
    check("tie a.done", 64'(dn_a), 1);

    // Reset in the middle of DRAIN aborts the drain.
    do_clr();
    tick(3);
    halt = 1'b1; ret_val = 16'd9;
    tick(1);
    halt = 1'b0;
    tick(1);
    check("abort a.state drain", 64'(st_a), 1);
    rst_n = 1'b0;
    #1;
    check("abort a.state async", 64'(st_a), 0);
    check("abort a.ret_q async", 64'(rq_a), 0);
    tick(2);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      check("abort a.done stays low", 64'(dn_a), 0);
    end
    check("abort a.cycle_cnt", 64'(cy_a), 5);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
